button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter_pkg.sv | 11 +
 rtl/btn_edge_flags.sv | 40 ++++
 rtl/button_event_arbiter.sv | 108 ++++++++++
 tb/tb_button_event_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared constants for the button event arbiter: default sizing and the
// encoding carried on evt_release.
package button_event_arbiter_pkg;

  localparam int N_BTN_DEFAULT = 4;
  localparam int ID_W_DEFAULT  = $clog2(N_BTN_DEFAULT);

  localparam logic EVT_PRESS   = 1'b0;
  localparam logic EVT_RELEASE = 1'b1;

endpackage

// File: rtl/btn_edge_flags.sv
// Per-button edge detector with sticky press/release pending flags and
// a one-cycle overflow indication when an edge lands on an unserved flag.
module btn_edge_flags
  import button_event_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic serve_press,
  input  logic serve_release,
  output logic pend_press,
  output logic pend_release,
  output logic ovf_evt
);

  logic prev;
  logic press_edge;
  logic release_edge;

  assign press_edge   = level & ~prev;
  assign release_edge = ~level & prev;

  // A new edge on a flag that is being served in the same cycle is a fresh
  // event rather than a lost one, so only unserved flags count as overflow.
  assign ovf_evt = (press_edge & pend_press & ~serve_press)
                 | (release_edge & pend_release & ~serve_release);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev         <= 1'b0;
      pend_press   <= 1'b0;
      pend_release <= 1'b0;
    end else begin
      prev         <= level;
      pend_press   <= press_edge | (pend_press & ~serve_press);
      pend_release <= release_edge | (pend_release & ~serve_release);
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Collects press/release edges from N_BTN buttons and serialises them
// through a round-robin arbiter into a valid/ready event stream.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEFAULT,
  parameter int ID_W  = $clog2(N_BTN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTN-1:0]  btn_level,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  output logic              evt_release,
  input  logic              evt_ready,
  output logic [N_BTN-1:0]  ovf,
  input  logic              ovf_clr
);

  logic [N_BTN-1:0] pend_press;
  logic [N_BTN-1:0] pend_release;
  logic [N_BTN-1:0] serve_press;
  logic [N_BTN-1:0] serve_release;
  logic [N_BTN-1:0] ovf_evt;
  logic [N_BTN-1:0] req;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  rr_next;
  logic [ID_W:0]    cand;
  logic [ID_W:0]    next_sum;
  logic             grant_found;
  logic             free;
  logic             grant;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_edge_flags u_flags (
      .clk           (clk),
      .reset         (reset),
      .level         (btn_level[i]),
      .serve_press   (serve_press[i]),
      .serve_release (serve_release[i]),
      .pend_press    (pend_press[i]),
      .pend_release  (pend_release[i]),
      .ovf_evt       (ovf_evt[i])
    );
  end

  assign req   = pend_press | pend_release;
  assign free  = ~evt_valid | evt_ready;
  assign grant = free & grant_found;

  // First requesting button at or above rr_ptr, wrapping modulo N_BTN.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < N_BTN; off++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(N_BTN)) begin
        cand = cand - (ID_W+1)'(N_BTN);
      end
      if (!grant_found && req[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign next_sum = {1'b0, grant_idx} + (ID_W+1)'(1);
  assign rr_next  = (next_sum == (ID_W+1)'(N_BTN)) ? '0 : next_sum[ID_W-1:0];

  // Press is served ahead of release for the granted button.
  always_comb begin
    serve_press   = '0;
    serve_release = '0;
    if (grant) begin
      serve_press[grant_idx]   = pend_press[grant_idx];
      serve_release[grant_idx] = ~pend_press[grant_idx] & pend_release[grant_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      evt_release <= EVT_PRESS;
      rr_ptr      <= '0;
    end else if (grant) begin
      evt_valid   <= 1'b1;
      evt_id      <= grant_idx;
      evt_release <= pend_press[grant_idx] ? EVT_PRESS : EVT_RELEASE;
      rr_ptr      <= rr_next;
    end else if (free) begin
      evt_valid   <= 1'b0;
    end
  end

  // Clearing is applied first so a same-cycle overflow still sets its bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{N_BTN{ovf_clr}}) | ovf_evt;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios plus a
// randomized run compared against an event-level reference model.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  btn_level = '0;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_release;
  logic          evt_ready = 1'b1;
  logic [N-1:0]  ovf;
  logic          ovf_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: pending events per button and the visible event.
  bit       m_prev [N];
  bit       m_pp   [N];
  bit       m_pr   [N];
  int       m_rr;
  bit       m_valid;
  int       m_id;
  bit       m_rel;
  bit [N-1:0] m_ovf;

  button_event_arbiter #(.N_BTN(N), .ID_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_level   (btn_level),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_release (evt_release),
    .evt_ready   (evt_ready),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b0;
      m_pp[i]   = 1'b0;
      m_pr[i]   = 1'b0;
    end
    m_rr = 0; m_valid = 1'b0; m_id = 0; m_rel = 1'b0; m_ovf = '0;
  endtask

  task automatic model_cycle();
    bit free;
    int g;
    bit sp [N];
    bit sr [N];
    bit pe, re;
    free = !m_valid || evt_ready;
    g = -1;
    if (free) begin
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (m_rr + off) % N;
        if (g < 0 && (m_pp[idx] || m_pr[idx])) g = idx;
      end
    end
    for (int i = 0; i < N; i++) begin
      sp[i] = (g == i) && m_pp[i];
      sr[i] = (g == i) && !m_pp[i] && m_pr[i];
    end
    if (ovf_clr) m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      pe = btn_level[i] && !m_prev[i];
      re = !btn_level[i] && m_prev[i];
      if ((pe && m_pp[i] && !sp[i]) || (re && m_pr[i] && !sr[i])) m_ovf[i] = 1'b1;
      m_pp[i]   = pe || (m_pp[i] && !sp[i]);
      m_pr[i]   = re || (m_pr[i] && !sr[i]);
      m_prev[i] = btn_level[i];
    end
    if (g >= 0) begin
      m_valid = 1'b1;
      m_id    = g;
      m_rel   = !sp[g];
      m_rr    = (g + 1) % N;
    end else if (free) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_clear();
    else model_cycle();
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] lvl);
    btn_level = lvl;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    reset     = 1'b1;
    model_clear();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    #1;
    n_vec++;
    if (evt_valid !== 1'b0 || evt_id !== 2'd0 || evt_release !== 1'b0 || ovf !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_state: got valid=%0b id=%0d rel=%0b ovf=%b, expected all zero",
               evt_valid, evt_id, evt_release, ovf);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_press();
    do_reset('0);
    for (int i = 0; i < 6; i++) step();
    btn_level = 4'b0100;
    step();
    n_vec++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL press_latency_early: got valid=%0b, expected 0", evt_valid);
    end
    step();
    n_vec++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_release !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL press_event: got valid=%0b id=%0d rel=%0b, expected valid=1 id=2 rel=0",
               evt_valid, evt_id, evt_release);
    end
    step();
    n_vec++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL press_one_cycle: got valid=%0b, expected 0", evt_valid);
    end
  endtask

  task automatic test_back_to_back();
    int exp_ids [3] = '{0, 1, 3};
    do_reset('0);
    btn_level = 4'b1011;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (evt_valid !== 1'b1 || evt_id !== IW'(exp_ids[k]) || evt_release !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL b2b_event%0d: got valid=%0b id=%0d rel=%0b, expected valid=1 id=%0d rel=0",
                 k, evt_valid, evt_id, evt_release, exp_ids[k]);
      end
    end
    step();
    n_vec++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_drain: got valid=%0b, expected 0", evt_valid);
    end
    // Pointer wrapped back to 0, so button 1 must win over button 3.
    btn_level = 4'b0001;
    step();
    step();
    n_vec++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_release !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_rr_wrap_first: got valid=%0b id=%0d rel=%0b, expected valid=1 id=1 rel=1",
               evt_valid, evt_id, evt_release);
    end
    step();
    n_vec++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_release !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_rr_wrap_second: got valid=%0b id=%0d rel=%0b, expected valid=1 id=3 rel=1",
               evt_valid, evt_id, evt_release);
    end
  endtask

  task automatic test_backpressure();
    do_reset('0);
    evt_ready = 1'b0;
    btn_level = 4'b0010;
    step();
    step();
    btn_level = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_release !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL stall_hold%0d: got valid=%0b id=%0d rel=%0b, expected valid=1 id=1 rel=0",
                 k, evt_valid, evt_id, evt_release);
      end
    end
    evt_ready = 1'b1;
    step();
    n_vec++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_release !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL stall_release: got valid=%0b id=%0d rel=%0b, expected valid=1 id=1 rel=1",
               evt_valid, evt_id, evt_release);
    end
    step();
    n_vec++;
    if (evt_valid !== 1'b0 || ovf !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL stall_drain: got valid=%0b ovf=%b, expected valid=0 ovf=0000", evt_valid, ovf);
    end
  endtask

  task automatic test_overflow();
    do_reset('0);
    evt_ready = 1'b0;
    btn_level = 4'b0010; step();
    btn_level = 4'b0000; step();
    btn_level = 4'b0010; step();
    btn_level = 4'b0000; step();
    step();
    step();
    n_vec++;
    if (ovf !== 4'b0010 || evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_release !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ovf_set: got ovf=%b valid=%0b id=%0d rel=%0b, expected ovf=0010 valid=1 id=1 rel=0",
               ovf, evt_valid, evt_id, evt_release);
    end
    evt_ready = 1'b1;
    step();
    n_vec++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_release !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ovf_press_delivered: got valid=%0b id=%0d rel=%0b, expected valid=1 id=1 rel=0",
               evt_valid, evt_id, evt_release);
    end
    step();
    n_vec++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_release !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ovf_release_delivered: got valid=%0b id=%0d rel=%0b, expected valid=1 id=1 rel=1",
               evt_valid, evt_id, evt_release);
    end
    step();
    n_vec++;
    if (evt_valid !== 1'b0 || ovf !== 4'b0010) begin
      n_err++;
      $display("[TB] FAIL ovf_sticky: got valid=%0b ovf=%b, expected valid=0 ovf=0010", evt_valid, ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_vec++;
    if (ovf !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL ovf_clear: got ovf=%b, expected 0000", ovf);
    end
  endtask

  task automatic test_reset_mid();
    do_reset('0);
    evt_ready = 1'b0;
    btn_level = 4'b1101;
    step();
    step();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    n_vec++;
    if (evt_valid !== 1'b0 || evt_id !== 2'd0 || evt_release !== 1'b0 || ovf !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_mid_async: got valid=%0b id=%0d rel=%0b ovf=%b, expected all zero",
               evt_valid, evt_id, evt_release, ovf);
    end
    btn_level = '0;
    evt_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_vec++;
      if (evt_valid !== 1'b0 || ovf !== 4'b0000) begin
        n_err++;
        $display("[TB] FAIL reset_mid_quiet%0d: got valid=%0b ovf=%b, expected valid=0 ovf=0000",
                 k, evt_valid, ovf);
      end
    end
  endtask

  task automatic test_held_through_reset();
    do_reset(4'b1111);
    step();
    for (int k = 0; k < N; k++) begin
      step();
      n_vec++;
      if (evt_valid !== 1'b1 || evt_id !== IW'(k) || evt_release !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL held_press%0d: got valid=%0b id=%0d rel=%0b, expected valid=1 id=%0d rel=0",
                 k, evt_valid, evt_id, evt_release, k);
      end
    end
    step();
    n_vec++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL held_drain: got valid=%0b, expected 0", evt_valid);
    end
  endtask

  task automatic test_random();
    logic [IW+N+1:0] got, exp;
    do_reset('0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) btn_level[i] = ~btn_level[i];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      step();
      got = {evt_valid, evt_id, evt_release, ovf};
      exp = {m_valid, m_id[IW-1:0], m_rel, m_ovf};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("[TB] FAIL random_cycle%0d: got {valid,id,rel,ovf}=%b, expected %b", c, got, exp);
      end
    end
    ovf_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_held_through_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
